gshare_pht_ctrl: RTL and testbench
==================================

Name: gshare_pht_ctrl

Overview:
- Controller and initiator for the dual-port flop array (`sp_ff_array_dp`) used as the gshare pattern history table (PHT).
- Port 0 serves fetch-time predictions.
- Port 1 performs commit-time read-modify-write updates of 2-bit saturating counters.
- Owns the global history register (GHR) and the index hash, and forwards in-flight writes so predictions never see stale counters.

Parameters:
- S_INDEX, 4, PHT index width; table has 2**S_INDEX entries; GHR width = S_INDEX.
- WIDTH, 2, counter width; fixed at 2, elaboration error otherwise.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- pred_valid  in  1  lookup request this cycle.
- pred_pc  in  32  fetch PC.
- pred_resp_valid  out  1  prediction valid (one cycle after pred_valid).
- pred_taken  out  1  predicted direction.
- pred_index  out  S_INDEX  index used; carried down the pipe for the update.
- upd_valid  in  1  resolved-branch update offered.
- upd_ready  out  1  update accepted when upd_valid & upd_ready.
- upd_index  in  S_INDEX  index returned from prediction.
- upd_taken  in  1  actual outcome.
- ghr  out  S_INDEX  current global history.
- arr_csb0, arr_web0  out  1  port-0 chip select / write enable (active-low).
- arr_addr0  out  S_INDEX  port-0 address.
- arr_din0  out  WIDTH  port-0 write data (unused, driven 0).
- arr_dout0  in  WIDTH  port-0 read data.
- arr_csb1, arr_web1, arr_addr1, arr_din1, arr_dout1  same shape, port 1.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Array contract:
  - Inputs are registered on csb=0; a write driven in cycle W lands in the array at edge W+2.
  - A read driven in cycle k returns in cycle k+1 and sees writes driven up to cycle k-1.
- Port 0:
  - arr_csb0=0 and arr_web0=1 always; arr_addr0 = pred_pc[S_INDEX+1:2] ^ ghr, combinational.
  - Registered request: p_v, p_idx. pred_resp_valid = p_v; pred_index = p_idx.
  - pred_taken = counter[1], where counter = forwarded data if fwd_v & fwd_idx==p_idx, else arr_dout0.
- Port 1:
  - arr_csb1=0 always, so the array's registered write enable never sticks low.
  - arr_web1=0 only in state WR.
- FSM: IDLE, WR.
  - IDLE: upd_ready=1; addr1=upd_index; web1=1.
    - On handshake: latch u_idx and u_taken; ghr <= {ghr[S_INDEX-2:0], upd_taken}; go to WR.
  - WR: upd_ready=0; arr_dout1 holds the old counter.
    - new = taken ? min(old+1,3) : max(old-1,0).
    - Drive web1=0, addr1=u_idx, din1=new; go to IDLE.
  - Throughput: 1 update per 2 cycles.
  - Back-to-back updates to the same index need no forwarding: the read issued in the IDLE after WR already sees the write.
- Forwarding register: fwd_v <= (state==WR); fwd_idx <= u_idx; fwd_data <= new.
  - This covers a prediction read issued in the same cycle as the write.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. The array resets to 0.
- Reset values: state=IDLE; ghr=0; p_v=0; fwd_v=0; pred_resp_valid=0; upd_ready=0 during the rst cycle, 1 after.
- Reset mid-update: the WR write is dropped; the array clears in the same cycle.
- Simultaneous predict and update to the same index: the prediction returns the pre-update value unless the write was driven in the same cycle as the prediction (forwarded).
- The GHR shift is non-speculative (at update acceptance). A prediction in the same cycle as acceptance hashes with the old GHR.

Decomposition:
- Shared package bp_pkg:
  - counter typedef (logic [1:0]).
  - Constants SNT/WNT/WT/ST.
  - Function sat_update(counter, taken).
- One sub-module: gshare_index_hash (pc, ghr -> index). The FSM and forwarding stay in the top.
- Bench instantiates the controller with the real sp_ff_array_dp.

Test Plan:
1. After reset, pred_valid with pred_pc=0x40 -> next cycle pred_resp_valid=1, pred_taken=0, pred_index=0x0.
2. Updates to index 5 with taken=1, three times, 2-cycle spacing -> counter reads 1,2,3; fourth taken stays 3; then one not-taken -> 2.
3. upd_valid held high for 6 cycles -> upd_ready pattern 1,0,1,0,1,0; exactly 3 writes; ghr = 0b0111 when all taken.
4. Update idx 3 (old 1, taken) -> WR in cycle W; pred to idx 3 driven in cycle W -> pred_taken=1 (forwarded value 2); without forwarding it would read 0.
5. After ghr=0b0111, pred_pc=0x1C -> arr_addr0 = 0x7 ^ 0x7 = 0, pred_index=0.
6. Assert rst during WR -> no write lands; all entries read 0; ghr=0; upd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor counter type, encodings, update FSM states and saturating update
package bp_pkg;
  typedef logic [1:0] counter_t;
  typedef enum logic {IDLE, WR} upd_state_t;
  localparam counter_t SNT = 2'd0;
  localparam counter_t WNT = 2'd1;
  localparam counter_t WT  = 2'd2;
  localparam counter_t ST  = 2'd3;
  function automatic counter_t sat_update(counter_t c, logic taken);
    return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/gshare_index_hash.sv
// gshare_index_hash: folds the word-aligned fetch PC with the global history into a PHT index
module gshare_index_hash #(
  parameter int S_INDEX = 4
) (
  input  logic [31:0]        pc,
  input  logic [S_INDEX-1:0] ghr,
  output logic [S_INDEX-1:0] index
);
  logic unused_pc;
  assign unused_pc = ^{pc[31:S_INDEX+2], pc[1:0]};
  assign index = pc[S_INDEX+1:2] ^ ghr;
endmodule

// File: rtl/sp_ff_array_dp.sv
// sp_ff_array_dp: dual-port flop array with registered inputs; a write lands two edges after it is driven
module sp_ff_array_dp #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csb0,
  input  logic               web0,
  input  logic [S_INDEX-1:0] addr0,
  input  logic [WIDTH-1:0]   din0,
  output logic [WIDTH-1:0]   dout0,
  input  logic               csb1,
  input  logic               web1,
  input  logic [S_INDEX-1:0] addr1,
  input  logic [WIDTH-1:0]   din1,
  output logic [WIDTH-1:0]   dout1
);
  logic [WIDTH-1:0] mem [2**S_INDEX];
  logic web0_r, web1_r;
  logic [S_INDEX-1:0] addr0_r, addr1_r;
  logic [WIDTH-1:0] din0_r, din1_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**S_INDEX; i++) mem[i] <= '0;
      web0_r <= 1'b1;
      web1_r <= 1'b1;
      addr0_r <= '0;
      addr1_r <= '0;
      din0_r <= '0;
      din1_r <= '0;
    end else begin
      if (!csb0) begin
        web0_r <= web0;
        addr0_r <= addr0;
        din0_r <= din0;
      end
      if (!csb1) begin
        web1_r <= web1;
        addr1_r <= addr1;
        din1_r <= din1;
      end
      if (!web0_r) mem[addr0_r] <= din0_r;
      if (!web1_r) mem[addr1_r] <= din1_r;
    end
  end
  assign dout0 = mem[addr0_r];
  assign dout1 = mem[addr1_r];
endmodule

// File: rtl/gshare_pht_ctrl.sv
// gshare_pht_ctrl: gshare PHT controller; port 0 predicts, port 1 does read-modify-write counter updates
module gshare_pht_ctrl import bp_pkg::*; #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pred_valid,
  input  logic [31:0]        pred_pc,
  output logic               pred_resp_valid,
  output logic               pred_taken,
  output logic [S_INDEX-1:0] pred_index,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [S_INDEX-1:0] upd_index,
  input  logic               upd_taken,
  output logic [S_INDEX-1:0] ghr,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  output logic [WIDTH-1:0]   arr_din0,
  input  logic [WIDTH-1:0]   arr_dout0,
  output logic               arr_csb1,
  output logic               arr_web1,
  output logic [S_INDEX-1:0] arr_addr1,
  output logic [WIDTH-1:0]   arr_din1,
  input  logic [WIDTH-1:0]   arr_dout1
);
  if (WIDTH != 2) begin : g_bad_width
    $error("gshare_pht_ctrl: WIDTH must be 2");
  end
  upd_state_t state, state_n;
  logic p_v, fwd_v, u_taken, accept;
  logic [S_INDEX-1:0] p_idx, u_idx, fwd_idx, hash_idx;
  counter_t fwd_data, new_c, rd_c;
  gshare_index_hash #(.S_INDEX(S_INDEX)) u_hash (.pc(pred_pc), .ghr(ghr), .index(hash_idx));
  assign arr_csb0 = 1'b0;
  assign arr_web0 = 1'b1;
  assign arr_addr0 = hash_idx;
  assign arr_din0 = '0;
  assign arr_csb1 = 1'b0;
  assign arr_din1 = new_c;
  assign pred_resp_valid = p_v;
  assign pred_index = p_idx;
  // The array cannot yet show a write driven in the same cycle as the prediction read
  assign rd_c = (fwd_v && fwd_idx == p_idx) ? fwd_data : arr_dout0;
  assign pred_taken = rd_c >= WT;
  assign new_c = sat_update(arr_dout1, u_taken);
  assign accept = upd_ready && upd_valid;
  always_comb begin
    upd_ready = (state == IDLE) && !rst;
    arr_web1 = state != WR;
    arr_addr1 = (state == WR) ? u_idx : upd_index;
    state_n = (state == IDLE && upd_valid && !rst) ? WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ghr <= '0;
      p_v <= 1'b0;
      fwd_v <= 1'b0;
    end else begin
      state <= state_n;
      p_v <= pred_valid;
      fwd_v <= state == WR;
      if (accept) ghr <= {ghr[S_INDEX-2:0], upd_taken};
    end
    p_idx <= hash_idx;
    fwd_idx <= u_idx;
    fwd_data <= new_c;
    if (accept) begin
      u_idx <= upd_index;
      u_taken <= upd_taken;
    end
  end
endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// tb_gshare_pht_ctrl: directed bench for the gshare PHT controller driving the real flop array
module tb_gshare_pht_ctrl;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst, pred_valid, pred_resp_valid, pred_taken, upd_valid, upd_ready, upd_taken;
  logic [31:0] pred_pc;
  logic [S-1:0] pred_index, upd_index, ghr, arr_addr0, arr_addr1;
  logic arr_csb0, arr_web0, arr_csb1, arr_web1;
  logic [1:0] arr_din0, arr_dout0, arr_din1, arr_dout1;
  int total = 0, bad = 0, wr_cnt = 0;
  logic [S-1:0] exp_ghr;

  always #5 clk = ~clk;

  sp_ff_array_dp #(.S_INDEX(S), .WIDTH(2)) u_arr (
    .clk(clk), .rst(rst),
    .csb0(arr_csb0), .web0(arr_web0), .addr0(arr_addr0), .din0(arr_din0), .dout0(arr_dout0),
    .csb1(arr_csb1), .web1(arr_web1), .addr1(arr_addr1), .din1(arr_din1), .dout1(arr_dout1)
  );

  gshare_pht_ctrl #(.S_INDEX(S), .WIDTH(2)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_taken(upd_taken),
    .ghr(ghr),
    .arr_csb0(arr_csb0), .arr_web0(arr_web0), .arr_addr0(arr_addr0), .arr_din0(arr_din0),
    .arr_dout0(arr_dout0),
    .arr_csb1(arr_csb1), .arr_web1(arr_web1), .arr_addr1(arr_addr1), .arr_din1(arr_din1),
    .arr_dout1(arr_dout1)
  );

  always @(negedge clk) if (!rst && !arr_web1) wr_cnt++;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_index = 0; upd_taken = 0;
    next_cycle();
    @(negedge clk);
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", upd_ready); end
    next_cycle();
    rst = 0;
    exp_ghr = '0;
    @(negedge clk);
    total++; if (pred_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0h exp=0", pred_resp_valid); end
    total++; if (ghr !== 4'h0) begin bad++; $display("FAIL rst_ghr got=%0h exp=0", ghr); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%0h exp=1", upd_ready); end
    total++; if (arr_csb1 !== 1'b0) begin bad++; $display("FAIL csb1 got=%0h exp=0", arr_csb1); end
    next_cycle();
    pred_valid = 1; pred_pc = 32'h40;
    @(negedge clk);
    total++; if (arr_addr0 !== 4'h0) begin bad++; $display("FAIL first_addr0 got=%0h exp=0", arr_addr0); end
    next_cycle();
    pred_valid = 0;
    @(negedge clk);
    total++; if (pred_resp_valid !== 1'b1) begin bad++; $display("FAIL first_resp_valid got=%0h exp=1", pred_resp_valid); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL first_taken got=%0h exp=0", pred_taken); end
    total++; if (pred_index !== 4'h0) begin bad++; $display("FAIL first_index got=%0h exp=0", pred_index); end
  endtask

  // One accepted update followed by its write cycle; exp_din is the hand-computed new counter
  task automatic do_update(input logic [S-1:0] idx, input logic taken, input logic [1:0] exp_din,
                           input logic with_pred, input logic [31:0] pc);
    logic [S-1:0] a;
    next_cycle();
    upd_valid = 1; upd_index = idx; upd_taken = taken; pred_valid = with_pred; pred_pc = pc;
    @(negedge clk);
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL upd_ready_idle got=%0h exp=1", upd_ready); end
    if (with_pred) begin
      a = pc[5:2] ^ exp_ghr;
      total++; if (arr_addr0 !== a) begin bad++; $display("FAIL hash_old_ghr got=%0h exp=%0h", arr_addr0, a); end
    end
    exp_ghr = {exp_ghr[S-2:0], taken};
    next_cycle();
    upd_valid = 0; pred_valid = 0;
    @(negedge clk);
    total++; if (arr_web1 !== 1'b0) begin bad++; $display("FAIL wr_web1 got=%0h exp=0", arr_web1); end
    total++; if (arr_addr1 !== idx) begin bad++; $display("FAIL wr_addr1 got=%0h exp=%0h", arr_addr1, idx); end
    total++; if (arr_din1 !== exp_din) begin bad++; $display("FAIL wr_din1 got=%0h exp=%0h", arr_din1, exp_din); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL upd_ready_wr got=%0h exp=0", upd_ready); end
    total++; if (ghr !== exp_ghr) begin bad++; $display("FAIL ghr_shift got=%0h exp=%0h", ghr, exp_ghr); end
  endtask

  task automatic test_saturate;
    do_update(4'd5, 1'b1, 2'd1, 1'b1, 32'h14);
    do_update(4'd5, 1'b1, 2'd2, 1'b0, 32'h0);
    do_update(4'd5, 1'b1, 2'd3, 1'b0, 32'h0);
    do_update(4'd5, 1'b1, 2'd3, 1'b0, 32'h0);
    do_update(4'd5, 1'b0, 2'd2, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back;
    int w0;
    logic [1:0] e;
    next_cycle();
    upd_valid = 1; upd_index = 4'd9; upd_taken = 1;
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (upd_ready !== ((i % 2) == 0)) begin bad++; $display("FAIL ready_pattern cyc=%0d got=%0h", i, upd_ready); end
      if (!arr_web1) begin
        e = 2'((i + 1) / 2);
        total++; if (arr_din1 !== e) begin bad++; $display("FAIL b2b_din got=%0h exp=%0h", arr_din1, e); end
      end
      next_cycle();
    end
    upd_valid = 0;
    exp_ghr = 4'b0111;
    @(negedge clk);
    total++; if (wr_cnt - w0 !== 3) begin bad++; $display("FAIL b2b_writes got=%0d exp=3", wr_cnt - w0); end
    total++; if (ghr !== 4'b0111) begin bad++; $display("FAIL b2b_ghr got=%0h exp=7", ghr); end
  endtask

  task automatic test_hash;
    next_cycle();
    pred_valid = 1; pred_pc = 32'h1C;
    @(negedge clk);
    total++; if (arr_addr0 !== 4'h0) begin bad++; $display("FAIL hash_addr0 got=%0h exp=0", arr_addr0); end
    next_cycle();
    pred_valid = 0;
    @(negedge clk);
    total++; if (pred_index !== 4'h0) begin bad++; $display("FAIL hash_index got=%0h exp=0", pred_index); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL hash_taken got=%0h exp=0", pred_taken); end
  endtask

  task automatic test_forward;
    logic [S-1:0] h;
    do_update(4'd3, 1'b1, 2'd1, 1'b0, 32'h0);
    next_cycle();
    upd_valid = 1; upd_index = 4'd3; upd_taken = 1;
    @(negedge clk);
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL fwd_accept got=%0h exp=1", upd_ready); end
    exp_ghr = {exp_ghr[S-2:0], 1'b1};
    next_cycle();
    upd_valid = 0;
    h = 4'd3 ^ exp_ghr;
    pred_valid = 1; pred_pc = {26'd0, h, 2'd0};
    @(negedge clk);
    total++; if (arr_din1 !== 2'd2) begin bad++; $display("FAIL fwd_din got=%0h exp=2", arr_din1); end
    next_cycle();
    @(negedge clk);
    total++; if (pred_index !== 4'd3) begin bad++; $display("FAIL fwd_index got=%0h exp=3", pred_index); end
    total++; if (arr_dout0 !== 2'd1) begin bad++; $display("FAIL fwd_stale_array got=%0h exp=1", arr_dout0); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL fwd_taken got=%0h exp=1", pred_taken); end
    next_cycle();
    pred_valid = 0;
    @(negedge clk);
    total++; if (arr_dout0 !== 2'd2) begin bad++; $display("FAIL landed_array got=%0h exp=2", arr_dout0); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL landed_taken got=%0h exp=1", pred_taken); end
  endtask

  task automatic test_reset_mid_update;
    int nz;
    next_cycle();
    upd_valid = 1; upd_index = 4'd12; upd_taken = 1;
    next_cycle();
    upd_valid = 0; rst = 1;
    @(negedge clk);
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0h exp=0", upd_ready); end
    next_cycle();
    rst = 0;
    exp_ghr = '0;
    @(negedge clk);
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%0h exp=1", upd_ready); end
    total++; if (ghr !== 4'h0) begin bad++; $display("FAIL mid_ghr got=%0h exp=0", ghr); end
    next_cycle();
    pred_valid = 1; pred_pc = 32'h0C;
    next_cycle();
    pred_valid = 0;
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_pred_taken got=%0h exp=0", pred_taken); end
    total++; if (pred_index !== 4'd3) begin bad++; $display("FAIL mid_pred_index got=%0h exp=3", pred_index); end
    nz = 0;
    for (int i = 0; i < 16; i++) if (u_arr.mem[i] !== 2'd0) nz++;
    total++; if (nz !== 0) begin bad++; $display("FAIL mid_nonzero_entries got=%0d exp=0", nz); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_back_to_back();
    test_hash();
    test_forward();
    test_reset_mid_update();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
